decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 79 +++++++
 tb/tb_decode_queue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: fetch-to-decode instruction FIFO with duplicate-PC filter and flush
module decode_queue #(
   parameter int XLEN = 32,
   parameter int DEPTH = 8,
   parameter int AFULL_TH = DEPTH-1,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_ins,
   input  logic [XLEN-1:0]  fetch_pc,
   input  logic [XLEN-1:0]  fetch_pred_pc,
   output logic             fetch_ready,
   input  logic             flush_in,
   input  logic             dec_ready,
   output logic             dec_valid,
   output logic [31:0]      dec_ins,
   output logic [XLEN-1:0]  dec_pc,
   output logic [XLEN-1:0]  dec_pred_pc,
   output logic             dec_is_c,
   output logic [XLEN-1:0]  dec_seq_pc,
   output logic [PTR_W:0]   count,
   output logic             almost_full,
   output logic             empty
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] AFULL = (PTR_W+1)'(AFULL_TH);
   logic [31:0]      ins_q  [DEPTH];
   logic [XLEN-1:0]  pc_q   [DEPTH];
   logic [XLEN-1:0]  pred_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [XLEN-1:0]  last_q, last_d, pc_m;
   logic             acc, wr, deq;
   assign pc_m        = {fetch_pc[XLEN-1:1], 1'b0};
   assign fetch_ready = rst_in && rdy_in && !flush_in && (count_q < FULL);
   assign empty       = count_q == '0;
   assign almost_full = count_q >= AFULL;
   assign count       = count_q;
   assign dec_valid   = rdy_in && !empty;
   assign acc         = fetch_valid && fetch_ready;
   // a re-offered PC (same halfword-aligned address) completes the handshake but is not stored
   assign wr          = acc && (pc_m != last_q);
   assign deq         = dec_valid && dec_ready;
   assign dec_ins     = ins_q[head_q];
   assign dec_pc      = pc_q[head_q];
   assign dec_pred_pc = pred_q[head_q];
   assign dec_is_c    = dec_ins[1:0] != 2'b11;
   assign dec_seq_pc  = dec_pc + (dec_is_c ? XLEN'(2) : XLEN'(4));
   always_comb begin
      head_d  = flush_in ? '0 : deq ? head_q + 1'b1 : head_q;
      tail_d  = flush_in ? '0 : wr ? tail_q + 1'b1 : tail_q;
      last_d  = flush_in ? '1 : acc ? pc_m : last_q;
      count_d = flush_in ? '0 : count_q + {{PTR_W{1'b0}}, wr} - {{PTR_W{1'b0}}, deq};
   end
   // rdy_in low freezes everything, flush included
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         last_q  <= '1;
      end else if (rdy_in) begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end
   always_ff @(posedge clk_in) begin
      if (wr) begin
         ins_q[tail_q]  <= fetch_ins;
         pc_q[tail_q]   <= pc_m;
         pred_q[tail_q] <= fetch_pred_pc;
      end
   end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scoreboard bench for decode_queue (DEPTH 8, XLEN 32)
module tb_decode_queue;
   logic        clk_in = 0, rst_in = 0, rdy_in = 1, fetch_valid = 0, flush_in = 0, dec_ready = 0;
   logic [31:0] fetch_ins = 0, fetch_pc = 0, fetch_pred_pc = 0;
   logic        fetch_ready, dec_valid, dec_is_c, almost_full, empty;
   logic [31:0] dec_ins, dec_pc, dec_pred_pc, dec_seq_pc;
   logic [3:0]  count;
   typedef struct {logic [31:0] ins, pc, pred;} ent_t;
   ent_t        sb[$];
   logic [31:0] m_last = '1;
   int          passes = 0, total = 0;

   always #5 clk_in = ~clk_in;

   decode_queue dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .fetch_valid(fetch_valid), .fetch_ins(fetch_ins), .fetch_pc(fetch_pc),
      .fetch_pred_pc(fetch_pred_pc), .fetch_ready(fetch_ready), .flush_in(flush_in),
      .dec_ready(dec_ready), .dec_valid(dec_valid), .dec_ins(dec_ins), .dec_pc(dec_pc),
      .dec_pred_pc(dec_pred_pc), .dec_is_c(dec_is_c), .dec_seq_pc(dec_seq_pc),
      .count(count), .almost_full(almost_full), .empty(empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // one clock with rdy high and no flush; checks outputs against the scoreboard, then updates it
   task automatic cyc(input logic fv, input logic [31:0] ins, input logic [31:0] pc, input logic dr);
      logic        acc, c;
      logic [31:0] msk;
      int          n;
      fetch_valid = fv; fetch_ins = ins; fetch_pc = pc; fetch_pred_pc = pc + 32'h100; dec_ready = dr;
      #1;
      n = sb.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("almost_full", 32'(almost_full), 32'(n >= 7));
      chk("fetch_ready", 32'(fetch_ready), 32'(n < 8));
      chk("dec_valid", 32'(dec_valid), 32'(n != 0));
      if (n != 0) begin
         c = sb[0].ins[1:0] != 2'b11;
         chk("dec_pc", dec_pc, sb[0].pc);
         chk("dec_ins", dec_ins, sb[0].ins);
         chk("dec_pred_pc", dec_pred_pc, sb[0].pred);
         chk("dec_is_c", 32'(dec_is_c), 32'(c));
         chk("dec_seq_pc", dec_seq_pc, sb[0].pc + (c ? 32'd2 : 32'd4));
      end
      acc = fv && n < 8;
      msk = {pc[31:1], 1'b0};
      if (dr && n != 0) void'(sb.pop_front());
      if (acc && msk != m_last) sb.push_back('{ins, msk, pc + 32'h100});
      if (acc) m_last = msk;
      @(posedge clk_in); #1;
   endtask

   initial begin
      fetch_valid = 1;
      #1;
      chk("rst_fetch_ready", 32'(fetch_ready), 0);
      chk("rst_dec_valid", 32'(dec_valid), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_almost_full", 32'(almost_full), 0);
      @(posedge clk_in); #1;
      chk("rst_count_held", 32'(count), 0);
      rst_in = 1; fetch_valid = 0;
      // fill, then a ninth offer that must be refused
      for (int i = 0; i < 8; i++) cyc(1, 32'h13, 32'(i * 4), 0);
      cyc(1, 32'h13, 32'h20, 0);
      chk("fill_count", 32'(count), 8);
      // wrap
      repeat (5) cyc(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(1, 32'h13, 32'h20 + 32'(i * 4), 0);
      repeat (8) cyc(0, 0, 0, 1);
      chk("wrap_empty", 32'(empty), 1);
      // duplicate filter
      cyc(1, 32'h13, 32'h100, 0);
      cyc(1, 32'h13, 32'h101, 0);
      cyc(1, 32'h13, 32'h104, 0);
      chk("dup_count", 32'(count), 2);
      chk("dup_head0", dec_pc, 32'h100);
      cyc(0, 0, 0, 1);
      chk("dup_head1", dec_pc, 32'h104);
      cyc(0, 0, 0, 1);
      // compressed and sequential PC
      cyc(1, 32'h00004501, 32'hFFFFFFFE, 0);
      chk("c_is_c", 32'(dec_is_c), 1);
      chk("c_pc", dec_pc, 32'hFFFFFFFE);
      chk("c_seq_wrap", dec_seq_pc, 32'h0);
      cyc(0, 0, 0, 1);
      cyc(1, 32'h00000013, 32'h8, 0);
      chk("i_seq", dec_seq_pc, 32'hC);
      cyc(0, 0, 0, 1);
      // flush with simultaneous enqueue and dequeue
      cyc(1, 32'h13, 32'h200, 0);
      cyc(1, 32'h13, 32'h204, 0);
      cyc(1, 32'h13, 32'h208, 0);
      fetch_valid = 1; fetch_pc = 32'h20C; dec_ready = 1; flush_in = 1;
      #1;
      chk("flush_fetch_ready", 32'(fetch_ready), 0);
      chk("flush_dec_valid_before", 32'(dec_valid), 1);
      @(posedge clk_in); #1;
      flush_in = 0; fetch_valid = 0; dec_ready = 0;
      sb.delete(); m_last = '1;
      chk("flush_count", 32'(count), 0);
      chk("flush_dec_valid", 32'(dec_valid), 0);
      cyc(1, 32'h13, 32'h208, 0);
      chk("refetch_count", 32'(count), 1);
      cyc(0, 0, 0, 1);
      // rdy_in low pauses everything
      cyc(1, 32'h13, 32'h300, 0);
      cyc(1, 32'h13, 32'h304, 0);
      rdy_in = 0; fetch_valid = 1; fetch_pc = 32'h308; dec_ready = 1;
      repeat (3) begin
         #1;
         chk("pause_fetch_ready", 32'(fetch_ready), 0);
         chk("pause_dec_valid", 32'(dec_valid), 0);
         chk("pause_count", 32'(count), 2);
         @(posedge clk_in); #1;
      end
      rdy_in = 1; fetch_valid = 0; dec_ready = 0;
      #1;
      chk("resume_count", 32'(count), 2);
      chk("resume_head", dec_pc, 32'h300);
      // asynchronous reset mid-cycle
      rst_in = 0;
      #1;
      chk("arst_empty", 32'(empty), 1);
      chk("arst_count", 32'(count), 0);
      chk("arst_dec_valid", 32'(dec_valid), 0);
      chk("arst_fetch_ready", 32'(fetch_ready), 0);
      sb.delete(); m_last = '1;
      @(posedge clk_in); #1;
      rst_in = 1;
      cyc(1, 32'h13, 32'h304, 0);
      chk("post_rst_count", 32'(count), 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
